// File: rtl/eight_queen_solution_reader.sv
// ============================================================================
// Module : eight_queen_solution_reader
// Brief  : Streams the 8-queen solver's solution stack as (col,row) pairs over
//          valid/ready. Optional QUEEN_VERIFY_EN adds a sticky conflict checker.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module eight_queen_solution_reader #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             mem_rd_en,
    output logic [IDX_W-1:0] mem_addr,
    input  logic [IDX_W-1:0] mem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_col,
    output logic [IDX_W-1:0] out_row,
    output logic             out_last,
    output logic             rd_done,
    output logic             sol_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_CAP  = 3'd2,
        S_SEND = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_col;
    logic [IDX_W-1:0] r_out_col;
    logic [IDX_W-1:0] r_out_row;
    logic             w_last_col;
    logic             w_handshake;
    logic             w_accept_start;

    assign w_last_col     = (r_col == IDX_W'(N - 1));
    assign w_handshake    = (r_state == S_SEND) && out_ready;
    assign w_accept_start = (r_state == S_IDLE) && start;

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        mem_rd_en   = 1'b0;
        mem_addr    = '0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        rd_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                busy        = 1'b1;
                mem_rd_en   = 1'b1;
                mem_addr    = r_col;
                w_state_nxt = S_CAP;
            end
            S_CAP: begin
                busy        = 1'b1;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = w_last_col;
                if (out_ready) w_state_nxt = w_last_col ? S_FIN : S_REQ;
            end
            S_FIN: begin
                busy        = 1'b1;
                rd_done     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_col     <= '0;
            r_out_col <= '0;
            r_out_row <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept_start) begin
                r_col <= '0;
            end else if (w_handshake && !w_last_col) begin
                r_col <= r_col + IDX_W'(1);
            end
            if (r_state == S_CAP) begin
                r_out_col <= r_col;
                r_out_row <= mem_rdata;
            end
        end
    end

    assign out_col = r_out_col;
    assign out_row = r_out_row;

`ifdef QUEEN_VERIFY_EN
    logic [N-1:0]     r_row_used;
    logic [2*N-2:0]   r_d1;
    logic [2*N-2:0]   r_d2;
    logic             r_sol_err;
    logic [IDX_W:0]   w_d1_idx;
    logic [IDX_W:0]   w_d2_idx;
    logic             w_row_oob;
    logic             w_conflict;

    // d2 is offset by N-1 so that col-row never goes negative.
    always_comb begin
        w_row_oob  = ({1'b0, mem_rdata} >= (IDX_W+1)'(N));
        w_d1_idx   = {1'b0, r_col} + {1'b0, mem_rdata};
        w_d2_idx   = {1'b0, r_col} + (IDX_W+1)'(N - 1) - {1'b0, mem_rdata};
        w_conflict = w_row_oob;
        if (!w_row_oob) begin
            w_conflict = r_row_used[mem_rdata] | r_d1[w_d1_idx] | r_d2[w_d2_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_used <= '0;
            r_d1       <= '0;
            r_d2       <= '0;
            r_sol_err  <= 1'b0;
        end else if (w_accept_start) begin
            r_row_used <= '0;
            r_d1       <= '0;
            r_d2       <= '0;
            r_sol_err  <= 1'b0;
        end else if (r_state == S_CAP) begin
            if (w_conflict) r_sol_err <= 1'b1;
            if (!w_row_oob) begin
                r_row_used[mem_rdata] <= 1'b1;
                r_d1[w_d1_idx]        <= 1'b1;
                r_d2[w_d2_idx]        <= 1'b1;
            end
        end
    end

    assign sol_err = r_sol_err;
`else
    assign sol_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_eight_queen_solution_reader.sv
// Testbench for eight_queen_solution_reader: directed readouts with a
// scoreboard queue of expected (col,row,last) pairs checked by a monitor.
`default_nettype none

module tb_eight_queen_solution_reader;

    localparam int N  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b1;
    logic [IW-1:0] mem_rdata = '0;
    logic          busy, mem_rd_en, out_valid, out_last, rd_done, sol_err;
    logic [IW-1:0] mem_addr, out_col, out_row;

    logic [IW-1:0] stack [N];

    typedef struct packed {
        logic [IW-1:0] col;
        logic [IW-1:0] row;
        logic          last;
    } pair_t;

    pair_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    rd_cnt = 0;

    eight_queen_solution_reader #(.N(N), .IDX_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_col   (out_col),
        .out_row   (out_row),
        .out_last  (out_last),
        .rd_done   (rd_done),
        .sol_err   (sol_err)
    );

    always #5 clk = ~clk;

    // Solution stack model: one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= stack[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_err(input logic cond);
`ifdef QUEEN_VERIFY_EN
        return cond;
`else
        return 1'b0;
`endif
    endfunction

    // Monitor: compares every accepted pair against the scoreboard.
    initial begin
        pair_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rd_done) rd_cnt++;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pair", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_col", out_col, e.col);
                    check("sb_row", out_row, e.row);
                    check("sb_last", out_last, e.last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [IW-1:0] s0, s1, s2, s3, s4, s5, s6, s7);
        stack[0] = s0; stack[1] = s1; stack[2] = s2; stack[3] = s3;
        stack[4] = s4; stack[5] = s5; stack[6] = s6; stack[7] = s7;
    endtask

    task automatic push_expect(input int upto);
        pair_t p;
        for (int c = 0; c < upto; c++) begin
            p.col  = IW'(c);
            p.row  = stack[c];
            p.last = (c == N - 1);
            exp_q.push_back(p);
        end
    endtask

    // Full lockstep readout; stall_col holds out_ready low, repulse_col
    // re-pulses start while busy, err_col is the first conflicting column.
    task automatic do_readout(input int stall_col, input int stall_n,
                              input int repulse_col, input int err_col);
        int rd_before;
        rd_before = rd_cnt;
        push_expect(N);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < N; c++) begin
            check("req_rd_en", mem_rd_en, 1'b1);
            check("req_addr", mem_addr, c);
            check("req_busy", busy, 1'b1);
            check("req_err", sol_err, exp_err(c > err_col));
            if (c == stall_col) out_ready = 1'b0;
            if (c == repulse_col) start = 1'b1;
            tick();
            start = 1'b0;
            check("cap_valid", out_valid, 1'b0);
            check("cap_rd_en", mem_rd_en, 1'b0);
            tick();
            check("send_valid", out_valid, 1'b1);
            check("send_col", out_col, c);
            check("send_row", out_row, stack[c]);
            check("send_last", out_last, (c == N - 1));
            check("send_err", sol_err, exp_err(c >= err_col));
            if (c == stall_col) begin
                for (int k = 0; k < stall_n; k++) begin
                    tick();
                    check("hold_valid", out_valid, 1'b1);
                    check("hold_col", out_col, c);
                    check("hold_row", out_row, stack[c]);
                    check("hold_rd_en", mem_rd_en, 1'b0);
                end
                out_ready = 1'b1;
            end
            tick();
        end
        check("fin_rd_done", rd_done, 1'b1);
        check("fin_busy", busy, 1'b1);
        check("fin_valid", out_valid, 1'b0);
        check("fin_err", sol_err, exp_err(err_col < N));
        tick();
        check("idle_rd_done", rd_done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_err", sol_err, exp_err(err_col < N));
        check("sb_empty", exp_q.size(), 0);
        check("rd_done_count", rd_cnt - rd_before, 1);
    endtask

    initial begin
        load(3'd0, 3'd4, 3'd7, 3'd5, 3'd2, 3'd6, 3'd1, 3'd3);
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_rd_en", mem_rd_en, 1'b0);
        check("rst_addr", mem_addr, 0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_col", out_col, 0);
        check("rst_row", out_row, 0);
        check("rst_last", out_last, 1'b0);
        check("rst_rd_done", rd_done, 1'b0);
        check("rst_err", sol_err, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // Plain readout, stall at col 3, restart pulse at col 2.
        do_readout(-1, 0, -1, N);
        do_readout(3, 5, -1, N);
        do_readout(-1, 0, 2, N);

        // Asynchronous reset while col 4 is being presented.
        push_expect(4);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        check("pre_rst_valid", out_valid, 1'b1);
        check("pre_rst_col", out_col, 4);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_valid", out_valid, 1'b0);
        check("arst_col", out_col, 0);
        check("arst_row", out_row, 0);
        check("arst_last", out_last, 1'b0);
        check("arst_rd_en", mem_rd_en, 1'b0);
        check("arst_sb_empty", exp_q.size(), 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("post_rst_idle_valid", out_valid, 1'b0);
            check("post_rst_idle_busy", busy, 1'b0);
            check("post_rst_idle_rd_en", mem_rd_en, 1'b0);
        end
        do_readout(-1, 0, -1, N);

        // Row 0 repeated at col 5, then back-to-back clean readout.
        load(3'd0, 3'd2, 3'd4, 3'd1, 3'd3, 3'd0, 3'd5, 3'd6);
        do_readout(-1, 0, -1, 5);
        load(3'd0, 3'd4, 3'd7, 3'd5, 3'd2, 3'd6, 3'd1, 3'd3);
        do_readout(-1, 0, -1, N);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
